// File: rtl/octant_rom_arbiter.sv
// Round-robin arbiter sharing one single-read-port octant ROM among NUM_REQ requesters.
// Each read carries its requester ID down a latency-matched tag pipe so that the data can be routed back.
module octant_rom_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ROM_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rom_ren,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_dout,
   output logic                      busy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]    ptr_reg, ptr_next;
   logic [NUM_REQ-1:0] pending_reg, pending_next;
   logic [NUM_REQ-1:0] eligible;
   logic [ID_W-1:0]    grant;
   logic               found;
   logic [ADDR_W-1:0]  addr_hold_reg;
   logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
   logic               tag_valid_reg [ROM_LATENCY];
   logic [ID_W-1:0]    tag_id_reg [ROM_LATENCY];

   assign eligible = req_valid & ~pending_reg;

   // First eligible index at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin : grant_search
      int idx;
      found = 1'b0;
      grant = ptr_reg;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_reg) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && eligible[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign req_ready[gi]  = found && (grant == ID_W'(gi));
      assign rsp_valid[gi]  = tag_valid_reg[ROM_LATENCY-1] &&
                              (tag_id_reg[ROM_LATENCY-1] == ID_W'(gi));
   end

   assign rom_ren  = found;
   assign rom_addr = found ? addr_slice[grant] : addr_hold_reg;
   assign rsp_data = tag_valid_reg[ROM_LATENCY-1] ? rom_dout : '0;
   assign busy     = |pending_reg;

   always_comb begin
      ptr_next = ptr_reg;
      if (found) begin
         ptr_next = (grant == LAST_ID) ? '0 : grant + ID_W'(1);
      end
   end

   // A requester can only be accepted while not pending, so set and clear never collide.
   assign pending_next = (pending_reg & ~rsp_valid) | req_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg       <= '0;
         pending_reg   <= '0;
         addr_hold_reg <= '0;
         for (int s = 0; s < ROM_LATENCY; s++) begin
            tag_valid_reg[s] <= 1'b0;
            tag_id_reg[s]    <= '0;
         end
      end else begin
         ptr_reg     <= ptr_next;
         pending_reg <= pending_next;
         if (found) begin
            addr_hold_reg <= addr_slice[grant];
         end
         tag_valid_reg[0] <= found;
         tag_id_reg[0]    <= grant;
         for (int s = 1; s < ROM_LATENCY; s++) begin
            tag_valid_reg[s] <= tag_valid_reg[s-1];
            tag_id_reg[s]    <= tag_id_reg[s-1];
         end
      end
   end

endmodule

// File: doc/octant_rom_arbiter.md
Name: octant_rom_arbiter

Overview:
- Shares one single-read-port octant ROM among NUM_REQ ray processors.
- Today each processor gets a dedicated ROM port; this block lets the core count scale without duplicating ROM ports.
- Grants round-robin, at most one ROM read per cycle, and tags each read with its requester ID.
- Routes each returning word, after the ROM's fixed read latency, back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of ray-processor requesters (2..8).
- ADDR_W, 32, octant ROM address width.
- DATA_W, 32, octant ROM node word width.
- ROM_LATENCY, 1, cycles from rom_ren/rom_addr sampled to rom_dout valid (1..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot accept, combinational, same cycle.
- rsp_valid  out  NUM_REQ  one-hot, registered; response data valid for requester i.
- rsp_data  out  DATA_W  returned node word, broadcast to all requesters.
- rom_ren  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_dout  in  DATA_W  ROM read data.
- busy  out  1  any request in flight.

Behaviour:
- Clock and reset: single clock domain (clk). reset_n is asynchronous, active-low.
- Reset values: rsp_valid=0, busy=0, round-robin pointer=0, pending=0, tag pipeline cleared. rsp_data=0 during reset.
- Eligibility: eligible[i] = req_valid[i] & ~pending[i]. Each requester has at most one outstanding read.
- Grant selection:
  - Combinational, first eligible index searched from ptr upward, wrapping modulo NUM_REQ.
  - req_ready[grant]=1, all other bits 0.
  - No eligible requester: req_ready=0 and rom_ren=0.
- Accept: accept = req_valid[i] & req_ready[i].
  - Same cycle: rom_ren=1 and rom_addr=req_addr slice i.
  - rom_addr holds its last value when idle.
- Pointer update on accept: ptr <= (grant+1) mod NUM_REQ. Pointer unchanged on idle cycles.
- Pending: pending[i] set on the clock edge ending the accept cycle; cleared on the edge ending the cycle in which rsp_valid[i]=1.
- Set/clear priority: set and clear never coincide for one i, because a new accept requires ~pending.
- Requester obligation: req_valid and req_addr held stable until accepted. The arbiter does not check this.
- Tag pipeline:
  - ROM_LATENCY-deep shift register of {valid, id}, id width clog2(NUM_REQ).
  - Entry pushed every cycle; valid=accept.
  - Output stage drives rsp_valid[id]=tag.valid and rsp_data=rom_dout.
- Response latency: accept in cycle t -> rsp_valid[i]=1 for exactly one cycle, t+ROM_LATENCY.
  - rsp_data is valid only while rsp_valid is nonzero and holds that word for that cycle only.
  - No back-pressure on responses; requesters must capture data in that cycle.
- Per-requester throughput: earliest next accept is at t+ROM_LATENCY+1.
  - Aggregate throughput with NUM_REQ > ROM_LATENCY: one read per cycle.
- Ordering: responses return in accept order (in-order ROM).
- Fairness: a continuously eligible requester is granted within NUM_REQ-1 grants to others.
- busy = |pending.
- Boundary conditions:
  - Single eligible requester: granted regardless of ptr.
  - ptr=NUM_REQ-1 and grant to NUM_REQ-1: ptr wraps to 0.
  - Requester drops req_valid before accept: no effect.
  - Requester drops req_valid while pending: no effect; response still delivered.
- Reset mid-operation: all in-flight tags and pending bits discarded. No rsp_valid is produced for reads accepted before reset, even though the ROM may still return data.

Test Plan:
- Single requester, ROM_LATENCY=1: req 0 addr 0x10, mem[0x10]=0xA5A50010.
  -> req_ready=4'b0001 in the same cycle, rom_addr=0x10.
  -> Next cycle: rsp_valid=4'b0001, rsp_data=0xA5A50010; busy high exactly 1 cycle.
- All four valid out of reset, addrs 0x0..0x3, held after accept: accepts in order 0,1,2,3 on cycles 0..3.
  -> rsp_valid 0001,0010,0100,1000 on cycles 1..4.
  -> Requester 0 re-accepted at cycle 4 at the earliest.
- Rotation: ptr=0; requesters 1 and 3 valid -> grant 1. Next cycle 0 and 3 valid -> grant 3 (ptr=2). Then 0 -> grant 0.
- Pending block, ROM_LATENCY=2: requester 0 alone, valid continuously -> accepts at cycles 0,3,6; rsp_valid[0] at 2,5,8.
- Reset mid-flight, ROM_LATENCY=3: accept req 2 at cycle 0, reset_n low at cycle 1.
  -> rsp_valid stays 0 through cycle 5, busy=0.
  -> After release, 4 valid requesters are granted starting at 0.
- Back-to-back, ROM_LATENCY=3: requesters 1,2,3 accepted cycles 0,1,2, with distinct data 0x11,0x22,0x33.
  -> rsp_valid one-hot 1,2,3 on cycles 3,4,5 with matching rsp_data.
